// File: rtl/bbq_pair_sched_pkg.sv
// Shared types for the paired bbq scheduler: heap op codes,
// default queue capacity and scheduler FSM states.
package bbq_pair_sched_pkg;

   typedef enum logic [1:0] {
      HEAP_OP_ENQUE      = 2'd0,
      HEAP_OP_DEQUE_MAX  = 2'd1,
      HEAP_OP_ENQUE_DEQUE = 2'd2
   } heap_op_t;

   localparam int BBQ_CAP_DEFAULT = 64;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      SWAP = 2'd2
   } sched_state_t;

endpackage

// File: rtl/bbq_pair_sched_occ.sv
// Per-queue occupancy counter; inc and dec in the same cycle cancel.
module bbq_occ_tracker
   import bbq_pair_sched_pkg::*;
#(
   parameter int CAP = BBQ_CAP_DEFAULT,
   localparam int OW = $clog2(CAP + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [OW-1:0] occ,
   output logic          full,
   output logic          empty
);

   logic [OW-1:0] occ_q, occ_d;

   always_comb begin
      occ_d = occ_q;
      if (inc && !dec) occ_d = occ_q + 1'b1;
      else if (dec && !inc) occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) occ_q <= '0;
      else occ_q <= occ_d;
   end

   assign occ   = occ_q;
   assign full  = (occ_q == OW'(CAP));
   assign empty = (occ_q == '0);

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(inc && !dec && full));
         assert (!(dec && !inc && empty));
      end
   end

endmodule

// File: rtl/bbq_pair_sched.sv
// Fill/drain ping-pong scheduler over two bbq heaps: enqueues fill one
// queue while max-dequeues drain the other; roles swap on threshold/empty.
module bbq_pair_sched
   import bbq_pair_sched_pkg::*;
#(
   parameter int DWIDTH       = 32,
   parameter int PRIOR_WIDTH  = 6,
   parameter int CAP          = BBQ_CAP_DEFAULT,
   parameter int SWAP_THRESH  = 10,
   parameter int MAX_INFLIGHT = 2,
   parameter int PEND_MAX     = 8,
   localparam int OW = $clog2(CAP + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DWIDTH-1:0]      in_data,
   input  logic [PRIOR_WIDTH-1:0] in_prior,
   input  logic                   deq_req,
   output logic                   deq_req_ready,
   output logic                   out_valid,
   output logic [DWIDTH-1:0]      out_data,
   output logic [PRIOR_WIDTH-1:0] out_prior,
   input  logic                   bbq0_ready,
   output logic                   bbq0_in_valid,
   output heap_op_t               bbq0_in_op_type,
   output logic [DWIDTH-1:0]      bbq0_in_he_data,
   output logic [PRIOR_WIDTH-1:0] bbq0_in_he_prio,
   input  logic                   bbq0_out_valid,
   input  heap_op_t               bbq0_out_op_type,
   input  logic [DWIDTH-1:0]      bbq0_out_he_data,
   input  logic [PRIOR_WIDTH-1:0] bbq0_out_he_prio,
   input  logic                   bbq1_ready,
   output logic                   bbq1_in_valid,
   output heap_op_t               bbq1_in_op_type,
   output logic [DWIDTH-1:0]      bbq1_in_he_data,
   output logic [PRIOR_WIDTH-1:0] bbq1_in_he_prio,
   input  logic                   bbq1_out_valid,
   input  heap_op_t               bbq1_out_op_type,
   input  logic [DWIDTH-1:0]      bbq1_out_he_data,
   input  logic [PRIOR_WIDTH-1:0] bbq1_out_he_prio,
   output logic                   fill_sel,
   output logic [OW-1:0]          occ0,
   output logic [OW-1:0]          occ1
);

   localparam int FW = $clog2(SWAP_THRESH + 1);
   localparam int PW = $clog2(PEND_MAX + 1);
   localparam int IW = $clog2(MAX_INFLIGHT + 1);

   sched_state_t           state_q, state_d;
   logic                   fill_sel_q, fill_sel_d;
   logic [FW-1:0]          fill_cnt_q, fill_cnt_d;
   logic [PW-1:0]          pend_q, pend_d;
   logic [IW-1:0]          inflight_q, inflight_d;
   logic                   out_valid_q, out_valid_d;
   logic [DWIDTH-1:0]      out_data_q, out_data_d;
   logic [PRIOR_WIDTH-1:0] out_prior_q, out_prior_d;

   logic [1:0] inc, dec, full, empty;
   logic run, f_rdy, d_rdy, f_full, f_empty, d_empty;
   logic swap_go, enq_fire, deq_fire, deq_acc;
   logic resp0, resp1, resp_fire;

   bbq_occ_tracker #(.CAP(CAP)) u_occ0 (
      .clk(clk), .rst(rst), .inc(inc[0]), .dec(dec[0]),
      .occ(occ0), .full(full[0]), .empty(empty[0])
   );

   bbq_occ_tracker #(.CAP(CAP)) u_occ1 (
      .clk(clk), .rst(rst), .inc(inc[1]), .dec(dec[1]),
      .occ(occ1), .full(full[1]), .empty(empty[1])
   );

   assign run     = (state_q == RUN);
   assign f_rdy   = fill_sel_q ? bbq1_ready : bbq0_ready;
   assign d_rdy   = fill_sel_q ? bbq0_ready : bbq1_ready;
   assign f_full  = full[fill_sel_q];
   assign f_empty = empty[fill_sel_q];
   assign d_empty = empty[~fill_sel_q];

   // Swap only with nothing in flight so responses always come from D.
   assign swap_go = run && (inflight_q == '0) &&
                    ((fill_cnt_q == FW'(SWAP_THRESH)) ||
                     (d_empty && !f_empty && (pend_q != '0)));

   assign in_ready = run && f_rdy && !f_full &&
                     (fill_cnt_q < FW'(SWAP_THRESH));
   assign enq_fire = in_valid && in_ready;
   assign deq_fire = run && !swap_go && (pend_q != '0) && !d_empty &&
                     d_rdy && (inflight_q < IW'(MAX_INFLIGHT));

   assign deq_req_ready = (state_q != INIT) && (pend_q < PW'(PEND_MAX));
   assign deq_acc       = deq_req && deq_req_ready;

   assign resp0 = bbq0_out_valid && (bbq0_out_op_type == HEAP_OP_DEQUE_MAX);
   assign resp1 = bbq1_out_valid && (bbq1_out_op_type == HEAP_OP_DEQUE_MAX);
   assign resp_fire = (resp0 || resp1) && (inflight_q != '0) &&
                      (state_q != INIT);

   always_ff @(posedge clk) begin
      if (rst) state_q <= INIT;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT: if (bbq0_ready && bbq1_ready) state_d = RUN;
         RUN:  if (swap_go) state_d = SWAP;
         SWAP: state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      bbq0_in_valid   = 1'b0;
      bbq0_in_op_type = HEAP_OP_ENQUE;
      bbq0_in_he_data = '0;
      bbq0_in_he_prio = '0;
      bbq1_in_valid   = 1'b0;
      bbq1_in_op_type = HEAP_OP_ENQUE;
      bbq1_in_he_data = '0;
      bbq1_in_he_prio = '0;
      inc = '0;
      dec = '0;
      if (enq_fire) begin
         inc[fill_sel_q] = 1'b1;
         if (fill_sel_q) begin
            bbq1_in_valid   = 1'b1;
            bbq1_in_he_data = in_data;
            bbq1_in_he_prio = in_prior;
         end else begin
            bbq0_in_valid   = 1'b1;
            bbq0_in_he_data = in_data;
            bbq0_in_he_prio = in_prior;
         end
      end
      if (deq_fire) begin
         dec[~fill_sel_q] = 1'b1;
         if (fill_sel_q) begin
            bbq0_in_valid   = 1'b1;
            bbq0_in_op_type = HEAP_OP_DEQUE_MAX;
         end else begin
            bbq1_in_valid   = 1'b1;
            bbq1_in_op_type = HEAP_OP_DEQUE_MAX;
         end
      end
   end

   always_comb begin
      fill_sel_d = fill_sel_q;
      fill_cnt_d = fill_cnt_q;
      if (state_q == SWAP) begin
         fill_sel_d = ~fill_sel_q;
         fill_cnt_d = '0;
      end else if (enq_fire) begin
         fill_cnt_d = fill_cnt_q + 1'b1;
      end
      pend_d      = pend_q + PW'(deq_acc) - PW'(deq_fire);
      inflight_d  = inflight_q + IW'(deq_fire) - IW'(resp_fire);
      out_valid_d = resp_fire;
      out_data_d  = '0;
      out_prior_d = '0;
      if (resp_fire) begin
         out_data_d  = resp0 ? bbq0_out_he_data : bbq1_out_he_data;
         out_prior_d = resp0 ? bbq0_out_he_prio : bbq1_out_he_prio;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_sel_q  <= 1'b0;
         fill_cnt_q  <= '0;
         pend_q      <= '0;
         inflight_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_prior_q <= '0;
      end else begin
         fill_sel_q  <= fill_sel_d;
         fill_cnt_q  <= fill_cnt_d;
         pend_q      <= pend_d;
         inflight_q  <= inflight_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_prior_q <= out_prior_d;
      end
   end

   assign fill_sel  = fill_sel_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_prior = out_prior_q;

   always @(posedge clk) begin
      if (!rst) begin
         assert (pend_q <= PW'(PEND_MAX));
         assert (inflight_q <= IW'(MAX_INFLIGHT));
         assert (!(resp0 && resp1));
      end
   end

endmodule

// File: tb/tb_bbq_pair_sched.sv
// Directed bench for bbq_pair_sched with a small behavioural bbq pair.
module tb_bbq_pair_sched;
   import bbq_pair_sched_pkg::*;

   localparam int RQ = 64;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready;
   logic [31:0] in_data;
   logic [5:0] in_prior;
   logic deq_req, deq_req_ready;
   logic out_valid;
   logic [31:0] out_data;
   logic [5:0] out_prior;
   logic rdy0, rdy1, hold;
   logic bbq0_in_valid, bbq1_in_valid;
   heap_op_t bbq0_in_op_type, bbq1_in_op_type;
   logic [31:0] bbq0_in_he_data, bbq1_in_he_data;
   logic [5:0] bbq0_in_he_prio, bbq1_in_he_prio;
   logic fill_sel;
   logic [6:0] occ0, occ1;

   logic [1:0] ov = '0;
   heap_op_t oop [2];
   logic [37:0] oent [2];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bbq_pair_sched dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_prior(in_prior),
      .deq_req(deq_req), .deq_req_ready(deq_req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_prior(out_prior),
      .bbq0_ready(rdy0), .bbq0_in_valid(bbq0_in_valid),
      .bbq0_in_op_type(bbq0_in_op_type),
      .bbq0_in_he_data(bbq0_in_he_data), .bbq0_in_he_prio(bbq0_in_he_prio),
      .bbq0_out_valid(ov[0]), .bbq0_out_op_type(oop[0]),
      .bbq0_out_he_data(oent[0][31:0]), .bbq0_out_he_prio(oent[0][37:32]),
      .bbq1_ready(rdy1), .bbq1_in_valid(bbq1_in_valid),
      .bbq1_in_op_type(bbq1_in_op_type),
      .bbq1_in_he_data(bbq1_in_he_data), .bbq1_in_he_prio(bbq1_in_he_prio),
      .bbq1_out_valid(ov[1]), .bbq1_out_op_type(oop[1]),
      .bbq1_out_he_data(oent[1][31:0]), .bbq1_out_he_prio(oent[1][37:32]),
      .fill_sel(fill_sel), .occ0(occ0), .occ1(occ1)
   );

   // Issue signals are snapshotted late in the low phase, then acted on at posedge.
   logic s_rst, s_hold;
   logic [1:0] s_iv, s_rdy;
   heap_op_t s_op [2];
   logic [37:0] s_ent [2];

   always @(negedge clk) begin
      #4;
      s_rst  = rst;
      s_hold = hold;
      s_iv   = {bbq1_in_valid, bbq0_in_valid};
      s_rdy  = {rdy1, rdy0};
      s_op[0]  = bbq0_in_op_type;
      s_op[1]  = bbq1_in_op_type;
      s_ent[0] = {bbq0_in_he_prio, bbq0_in_he_data};
      s_ent[1] = {bbq1_in_he_prio, bbq1_in_he_data};
   end

   logic [37:0] mem [2][64];
   int cnt [2];
   int ndeq [2];
   logic [37:0] rf [2][RQ];
   heap_op_t rop [2][RQ];
   int rh [2];
   int rt [2];

   initial begin
      for (int n = 0; n < 2; n++) begin
         cnt[n] = 0; ndeq[n] = 0; rh[n] = 0; rt[n] = 0;
      end
   end

   always @(posedge clk) begin
      int bi;
      logic [37:0] ent;
      for (int n = 0; n < 2; n++) begin
         if (!s_hold && rh[n] != rt[n]) begin
            ov[n]   <= 1'b1;
            oop[n]  <= rop[n][rh[n]];
            oent[n] <= rf[n][rh[n]];
            rh[n] = (rh[n] + 1) % RQ;
         end else begin
            ov[n] <= 1'b0;
         end
         if (s_rst) begin
            cnt[n] = 0;
         end else if (s_iv[n] && s_rdy[n]) begin
            ent = '0;
            if (s_op[n] == HEAP_OP_ENQUE) begin
               if (cnt[n] < 64) begin
                  mem[n][cnt[n]] = s_ent[n];
                  cnt[n]++;
               end
               ent = s_ent[n];
            end else begin
               ndeq[n]++;
               if (cnt[n] > 0) begin
                  bi = 0;
                  for (int j = 1; j < cnt[n]; j++)
                     if (mem[n][j][37:32] > mem[n][bi][37:32]) bi = j;
                  ent = mem[n][bi];
                  mem[n][bi] = mem[n][cnt[n]-1];
                  cnt[n]--;
               end
            end
            rf[n][rt[n]]  = ent;
            rop[n][rt[n]] = s_op[n];
            rt[n] = (rt[n] + 1) % RQ;
         end
      end
   end

   int out_n = 0;
   logic [5:0] log_p [64];
   logic [31:0] log_d [64];

   always @(negedge clk) begin
      if (out_valid && out_n < 64) begin
         log_p[out_n] = out_prior;
         log_d[out_n] = out_data;
         out_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_out(input string tag, input int n, input int budget);
      int k = 0;
      while (out_n < n && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, out_n, n);
   endtask

   int d0;

   initial begin
      rst = 1'b1; hold = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
      in_valid = 1'b0; in_data = '0; in_prior = '0; deq_req = 1'b0;
      cyc(); cyc();
      chk("rst_fill_sel", fill_sel, 0);
      chk("rst_occ0", occ0, 0);
      chk("rst_occ1", occ1, 0);
      chk("rst_out_valid", out_valid, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      chk("init_in_ready", in_ready, 0);
      chk("init_deq_ready", deq_req_ready, 0);
      rdy0 = 1'b1; rdy1 = 1'b1;
      cyc();
      chk("run_deq_ready", deq_req_ready, 1);
      chk("run_in_ready", in_ready, 1);

      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1; in_prior = 6'(i); in_data = 32'(100 + i);
         #1;
         chk("enq_ready", in_ready, 1);
         cyc();
      end
      in_valid = 1'b0;
      chk("thresh_in_ready", in_ready, 0);
      cyc();
      chk("swap_in_ready", in_ready, 0);
      chk("swap_sel_old", fill_sel, 0);
      cyc();
      chk("swap_sel_new", fill_sel, 1);
      chk("swap_occ0", occ0, 10);
      chk("swap_occ1", occ1, 0);
      chk("mdl_cnt0", cnt[0], 10);

      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_prior = 6'(20 + k); in_data = 32'(120 + k);
         deq_req = (k < 3);
         cyc();
      end
      in_valid = 1'b0; deq_req = 1'b0;
      wait_out("tmo_three", 3, 40);
      for (int i = 0; i < 5; i++) cyc();
      chk("three_cnt", out_n, 3);
      chk("deq_p0", log_p[0], 10);
      chk("deq_p1", log_p[1], 9);
      chk("deq_p2", log_p[2], 8);
      chk("deq_d0", log_d[0], 110);
      chk("mid_occ0", occ0, 7);
      chk("mid_occ1", occ1, 4);
      chk("mdl_cnt1", cnt[1], 4);

      deq_req = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      deq_req = 1'b0;
      wait_out("tmo_drain", 11, 120);
      chk("drain_p3", log_p[3], 7);
      chk("drain_p9", log_p[9], 1);
      chk("drain_p10", log_p[10], 23);
      chk("drain_d10", log_d[10], 123);
      chk("drain_sel", fill_sel, 0);
      chk("drain_occ0", occ0, 0);
      chk("drain_occ1", occ1, 3);

      deq_req = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      deq_req = 1'b0;
      wait_out("tmo_empty", 14, 60);
      chk("last_p13", log_p[13], 20);
      chk("empty_occ0", occ0, 0);
      chk("empty_occ1", occ1, 0);
      d0 = ndeq[0] + ndeq[1];
      deq_req = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      deq_req = 1'b0;
      chk("pend_full_rdy", deq_req_ready, 0);
      for (int i = 0; i < 5; i++) cyc();
      chk("empty_no_issue", ndeq[0] + ndeq[1], d0);
      chk("empty_no_out", out_n, 14);
      in_valid = 1'b1; in_prior = 6'd33; in_data = 32'd133;
      #1;
      chk("feed_in_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      wait_out("tmo_feed", 15, 30);
      chk("feed_p14", log_p[14], 33);
      chk("feed_d14", log_d[14], 133);
      chk("feed_sel", fill_sel, 1);
      chk("feed_deq_rdy", deq_req_ready, 1);

      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_prior = 6'(50 + i); in_data = 32'(150 + i);
         cyc();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      chk("re_sel", fill_sel, 1);
      chk("re_occ0", occ0, 10);
      hold = 1'b1;
      d0 = ndeq[0];
      deq_req = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      deq_req = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      chk("inflight_cap", ndeq[0] - d0, 2);
      chk("inflight_occ0", occ0, 8);
      chk("inflight_no_out", out_n, 15);
      rst = 1'b1;
      cyc();
      chk("mrst_in_ready", in_ready, 0);
      chk("mrst_deq_rdy", deq_req_ready, 0);
      chk("mrst_sel", fill_sel, 0);
      chk("mrst_occ0", occ0, 0);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_issue", bbq0_in_valid, 0);
      rst = 1'b0;
      hold = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      chk("late_resp_drop", out_n, 15);
      chk("post_rst_run", deq_req_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
